// File: rtl/pc_sequencer_if.sv
// ----------------------------------------------------------------------------
// pc_sequencer_if
// Instruction-memory fetch handshake between the PC sequencer and imem.
//   imem_req  : fetch request, held high until acknowledged (sequencer drives)
//   imem_addr : fetch address, equals the architectural PC (sequencer drives)
//   imem_ack  : instruction valid this cycle (memory drives)
// Modports: master = sequencer side, slave = memory side.
// ----------------------------------------------------------------------------
interface pc_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack
    );
endinterface

// File: rtl/pc_sequencer.sv
// ----------------------------------------------------------------------------
// pc_sequencer
// Owns the architectural program counter and sequences fetch/commit around
// the next-PC 2:1 mux. Each instruction is fetched (FETCH), then committed in
// a one-cycle window (EXEC, stall=0). A fetch that sees no acknowledge for
// MAX_WAIT request cycles, or a taken branch to a non word-aligned target,
// redirects the PC to TRAP_VECTOR through a one-cycle TRAP state.
//
// Ports:
//   clk           : system clock, rising-edge
//   rst_n         : synchronous active-low reset
//   imem          : fetch handshake (master modport of pc_sequencer_if)
//   stall         : hold the commit cycle
//   branch_taken  : branch decision, used in the commit cycle only
//   branch_target : branch target, used in the commit cycle only
//   PCSrc         : pc_mux select, 0 = PC+4, 1 = branch target
//   pc            : current program counter
//   instr_valid   : one-cycle commit pulse
//   trap          : one-cycle trap pulse
//   trap_cause    : 01 = fetch timeout, 10 = misaligned target (sticky)
// ----------------------------------------------------------------------------
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int unsigned MAX_WAIT     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pc_sequencer_if.master        imem,
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic [31:0]           branch_target,
    output logic                  PCSrc,
    output logic [31:0]           pc,
    output logic                  instr_valid,
    output logic                  trap,
    output logic [1:0]            trap_cause
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        TRAP  = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_NONE      = 2'b00;
    localparam logic [1:0] CAUSE_TIMEOUT   = 2'b01;
    localparam logic [1:0] CAUSE_MISALIGN  = 2'b10;

    // Last wait count before the timeout fires: the counter starts at 0 on
    // the first request cycle, so reaching MAX_WAIT-1 unacknowledged means
    // exactly MAX_WAIT request cycles have elapsed.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT) - 8'd1;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [7:0]  wait_cnt_r;
    logic [1:0]  trap_cause_r;
    logic        req_r;
    logic        trap_r;

    logic        commit_s;
    logic        take_s;
    logic        misalign_trap_s;
    logic [31:0] next_pc_s;

    // True when a word address has non-zero byte-offset bits.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

    // Commit-window decode and next-PC mux selection.
    always_comb begin
        commit_s        = 1'b0;
        take_s          = 1'b0;
        misalign_trap_s = 1'b0;
        next_pc_s       = pc_r + 32'd4;
        if ((state_r == EXEC) && !stall) begin
            commit_s = 1'b1;
            take_s   = branch_taken;
            if (branch_taken) begin
                next_pc_s       = branch_target;
                misalign_trap_s = is_misaligned(branch_target);
            end else begin
                next_pc_s       = pc_r + 32'd4;
                misalign_trap_s = 1'b0;
            end
        end else begin
            commit_s = 1'b0;
            take_s   = 1'b0;
        end
    end

    // Sequencer FSM: state, PC, wait counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            pc_r         <= RESET_VECTOR;
            wait_cnt_r   <= 8'd0;
            trap_cause_r <= CAUSE_NONE;
            req_r        <= 1'b0;
            trap_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_r <= FETCH;
                    req_r   <= 1'b1;
                    trap_r  <= 1'b0;
                end
                FETCH: begin
                    if (imem.imem_ack) begin
                        state_r    <= EXEC;
                        wait_cnt_r <= 8'd0;
                        req_r      <= 1'b0;
                    end else if (wait_cnt_r == WAIT_LAST) begin
                        state_r      <= TRAP;
                        wait_cnt_r   <= 8'd0;
                        req_r        <= 1'b0;
                        trap_r       <= 1'b1;
                        trap_cause_r <= CAUSE_TIMEOUT;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 8'd1;
                    end
                end
                EXEC: begin
                    if (!commit_s) begin
                        state_r <= EXEC;
                    end else if (misalign_trap_s) begin
                        // PC keeps the branch's own address; the vector is
                        // loaded on the way out of TRAP.
                        state_r      <= TRAP;
                        trap_r       <= 1'b1;
                        trap_cause_r <= CAUSE_MISALIGN;
                    end else begin
                        pc_r    <= next_pc_s;
                        state_r <= FETCH;
                        req_r   <= 1'b1;
                    end
                end
                TRAP: begin
                    pc_r    <= TRAP_VECTOR;
                    trap_r  <= 1'b0;
                    state_r <= FETCH;
                    req_r   <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                    req_r   <= 1'b0;
                    trap_r  <= 1'b0;
                end
            endcase
        end
    end

    assign imem.imem_req  = req_r;
    assign imem.imem_addr = pc_r;
    assign pc             = pc_r;
    assign trap           = trap_r;
    assign trap_cause     = trap_cause_r;
    // The commit pulse and mux select follow stall/branch_taken in the same
    // cycle, so they are decoded from the state register and live inputs.
    assign instr_valid    = commit_s;
    assign PCSrc          = take_s;

endmodule

// File: tb/tb_pc_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pc_sequencer
// Table-driven bench for pc_sequencer (MAX_WAIT=8). Each table row holds the
// inputs for one clock cycle and the outputs expected during that cycle.
// Rows are pushed to a scoreboard queue when driven and popped/compared at
// the falling edge. A hand-written sequence then checks first-request latency
// after a reset release.
// ----------------------------------------------------------------------------
module tb_pc_sequencer;

    typedef struct {
        logic        rst_n;
        logic        ack;
        logic        stall;
        logic        bt;
        logic [31:0] tgt;
        logic        req;
        logic [31:0] pc;
        logic        valid;
        logic        pcsrc;
        logic        trap;
        logic [1:0]  cause;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        PCSrc;
    logic [31:0] pc;
    logic        instr_valid;
    logic        trap;
    logic [1:0]  trap_cause;

    int checks;
    int errors;

    vec_t vecs[$];
    vec_t exp_q[$];

    pc_sequencer_if imem_if ();

    pc_sequencer #(
        .RESET_VECTOR (32'h0000_0000),
        .TRAP_VECTOR  (32'h0000_0100),
        .MAX_WAIT     (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem          (imem_if),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .PCSrc         (PCSrc),
        .pc            (pc),
        .instr_valid   (instr_valid),
        .trap          (trap),
        .trap_cause    (trap_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d got %h want %h", name, row, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic a, input logic s, input logic b, input logic [31:0] t,
                       input logic q, input logic [31:0] p, input logic v, input logic ps,
                       input logic tr, input logic [1:0] c);
        vec_t x;
        x.rst_n = r; x.ack = a; x.stall = s; x.bt = b; x.tgt = t;
        x.req = q; x.pc = p; x.valid = v; x.pcsrc = ps; x.trap = tr; x.cause = c;
        vecs.push_back(x);
    endtask

    initial begin
        vec_t e;
        int   n;
        checks = 0;
        errors = 0;
        rst_n         = 1'b0;
        imem_if.imem_ack = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0000_0000;

        //   rst  ack  stl  bt   target          req  pc              vld  src  trp  cause
        // Reset held low, then release with ack already high (ignored in IDLE)
        add(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 2'b00);
        add(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 2'b00);
        add(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 2'b00);
        // Sequential fetch/commit 0x0, 0x4, 0x8
        add(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 2'b00);
        add(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 2'b00);
        add(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0004, 1'b0, 1'b0, 1'b0, 2'b00);
        add(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0004, 1'b1, 1'b0, 1'b0, 2'b00);
        add(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 2'b00);
        // Taken branch at 0x8 to 0x40
        add(1'b1, 1'b1, 1'b0, 1'b1, 32'h40,        1'b0, 32'h0000_0008, 1'b1, 1'b1, 1'b0, 2'b00);
        // Branch inputs during FETCH are don't-care (misaligned, taken)
        add(1'b1, 1'b1, 1'b0, 1'b1, 32'h7,         1'b1, 32'h0000_0040, 1'b0, 1'b0, 1'b0, 2'b00);
        // Taken branch to misaligned 0x42 -> trap cause 10, pc held
        add(1'b1, 1'b1, 1'b0, 1'b1, 32'h42,        1'b0, 32'h0000_0040, 1'b1, 1'b1, 1'b0, 2'b00);
        add(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0040, 1'b0, 1'b0, 1'b1, 2'b10);
        add(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 2'b10);
        // Not-taken with misaligned target: no trap
        add(1'b1, 1'b1, 1'b0, 1'b0, 32'h3,         1'b0, 32'h0000_0100, 1'b1, 1'b0, 1'b0, 2'b10);
        // Fetch timeout: 8 unacknowledged request cycles
        for (int i = 0; i < 8; i++)
            add(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,     1'b1, 32'h0000_0104, 1'b0, 1'b0, 1'b0, 2'b10);
        add(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0104, 1'b0, 1'b0, 1'b1, 2'b01);
        // Ack on the 8th request cycle counts as success
        for (int i = 0; i < 7; i++)
            add(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,     1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 2'b01);
        add(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 2'b01);
        // Stall 5 cycles with branch_taken high, then commit to sampled target
        for (int i = 0; i < 5; i++)
            add(1'b1, 1'b1, 1'b1, 1'b1, 32'h300,   1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 2'b01);
        add(1'b1, 1'b1, 1'b0, 1'b1, 32'h200,       1'b0, 32'h0000_0100, 1'b1, 1'b1, 1'b0, 2'b01);
        add(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0200, 1'b0, 1'b0, 1'b0, 2'b01);
        // Jump to top word, then sequential commit wraps to 0
        add(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0000_0200, 1'b1, 1'b1, 1'b0, 2'b01);
        add(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 2'b01);
        add(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 2'b01);
        add(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 2'b01);
        add(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 2'b01);
        // Reset in FETCH with ack the same cycle
        add(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0004, 1'b0, 1'b0, 1'b0, 2'b01);
        add(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 2'b00);
        add(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 2'b00);
        add(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 2'b00);
        add(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 2'b00);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            rst_n            = vecs[i].rst_n;
            imem_if.imem_ack = vecs[i].ack;
            stall            = vecs[i].stall;
            branch_taken     = vecs[i].bt;
            branch_target    = vecs[i].tgt;
            exp_q.push_back(vecs[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            chk("imem_req", i, {31'd0, imem_if.imem_req}, {31'd0, e.req});
            chk("pc", i, pc, e.pc);
            if (e.req)
                chk("imem_addr", i, imem_if.imem_addr, e.pc);
            chk("instr_valid", i, {31'd0, instr_valid}, {31'd0, e.valid});
            chk("PCSrc", i, {31'd0, PCSrc}, {31'd0, e.pcsrc});
            chk("trap", i, {31'd0, trap}, {31'd0, e.trap});
            chk("trap_cause", i, {30'd0, trap_cause}, {30'd0, e.cause});
        end

        // First request appears in the 2nd cycle after rst_n rises
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (imem_if.imem_req) begin
                n = k;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("first_req_cycle", 0, n, 32'd2);
        chk("first_req_addr", 0, imem_if.imem_addr, 32'h0000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
